// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter
// Shares the RTC address/control bus between the initialisation sequencer,
// the set-time write machine and the display-refresh read sequencer.
// One owner at a time, each ownership bounded by HOLD_MAX cycles, and a
// GAP_CYCLES turnaround between owners.
//
// Ports:
//   clk                         system clock, rising edge
//   reset                       synchronous reset, active-low
//   req_init / req_wr / req_rd  bus requests
//   addr_init / addr_wr / addr_rd  per-requester address
//   gnt_init / gnt_wr / gnt_rd  one-hot (or zero) grants
//   bus_addr                    registered address of the current owner
//   bus_wr                      1 = write cycle (owner init or wr)
//   bus_busy                    1 while in OWN or GAP
//   timeout                     one-cycle pulse on a forced release
//
// Optional feature macro: ROUND_ROBIN_EN
//   defined   : wr/rd ties go to whichever was not granted most recently
//   undefined : fixed priority init > wr > rd

module rtc_bus_arbiter #(
  parameter logic [11:0] HOLD_MAX   = 12'h04a,
  parameter int          GAP_CYCLES = 4,
  parameter int          ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_init,
  input  logic              req_wr,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] addr_init,
  input  logic [ADDR_W-1:0] addr_wr,
  input  logic [ADDR_W-1:0] addr_rd,
  output logic              gnt_init,
  output logic              gnt_wr,
  output logic              gnt_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wr,
  output logic              bus_busy,
  output logic              timeout
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  typedef enum logic [1:0] {SRC_INIT = 2'd0, SRC_WR = 2'd1, SRC_RD = 2'd2} src_t;

  state_t              state_reg, state_next;
  src_t                owner_reg, owner_next;
  src_t                winner;
  logic [11:0]         hold_cnt_reg, hold_cnt_next;
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [2:0]          lock_reg, lock_next;
  logic [2:0]          gnt_reg, gnt_next;
  logic [ADDR_W-1:0]   bus_addr_reg, bus_addr_next;
  logic                bus_wr_reg, bus_wr_next;
  logic                bus_busy_reg, bus_busy_next;
  logic                timeout_reg, timeout_next;
  logic [2:0]          req_vec;
  logic [2:0]          elig;
  logic [ADDR_W-1:0]   owner_addr;
`ifdef ROUND_ROBIN_EN
  logic                last_wr_reg, last_wr_next;
`endif

  // Bit order everywhere: [0]=init, [1]=wr, [2]=rd.
  assign req_vec = {req_rd, req_wr, req_init};
  // A locked-out requester stays ineligible until it drops its request.
  assign elig    = req_vec & ~lock_reg;

  always_comb begin
    owner_addr = addr_init;
    case (owner_reg)
      SRC_WR:  owner_addr = addr_wr;
      SRC_RD:  owner_addr = addr_rd;
      default: owner_addr = addr_init;
    endcase
  end

  // Winner selection; init always dominates, wr/rd tie policy is configurable.
  always_comb begin
    winner = SRC_RD;
    if (elig[0]) begin
      winner = SRC_INIT;
    end else if (elig[1] && elig[2]) begin
`ifdef ROUND_ROBIN_EN
      winner = last_wr_reg ? SRC_RD : SRC_WR;
`else
      winner = SRC_WR;
`endif
    end else if (elig[1]) begin
      winner = SRC_WR;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    hold_cnt_next = hold_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    gnt_next      = gnt_reg;
    bus_addr_next = bus_addr_reg;
    bus_wr_next   = bus_wr_reg;
    bus_busy_next = bus_busy_reg;
    timeout_next  = 1'b0;
`ifdef ROUND_ROBIN_EN
    last_wr_next  = last_wr_reg;
`endif
    // Lockout clears on any edge where the request is low.
    for (int i = 0; i < 3; i++) begin
      lock_next[i] = req_vec[i] & lock_reg[i];
    end

    case (state_reg)
      IDLE: begin
        if (|elig) begin
          state_next    = OWN;
          owner_next    = winner;
          hold_cnt_next = 12'd1;
          gnt_next      = 3'(1) << winner;
          bus_busy_next = 1'b1;
`ifdef ROUND_ROBIN_EN
          if (winner == SRC_WR) last_wr_next = 1'b1;
          if (winner == SRC_RD) last_wr_next = 1'b0;
`endif
        end
      end

      OWN: begin
        if (!req_vec[owner_reg] || hold_cnt_reg == HOLD_MAX) begin
          // Request low wins over the hold limit: that is a normal release.
          state_next    = GAP;
          gap_cnt_next  = GAP_W'(1);
          gnt_next      = 3'b000;
          bus_addr_next = '0;
          bus_wr_next   = 1'b0;
          if (req_vec[owner_reg]) begin
            timeout_next = 1'b1;
            for (int i = 0; i < 3; i++) begin
              if (owner_reg == src_t'(i)) lock_next[i] = 1'b1;
            end
          end
        end else begin
          hold_cnt_next = hold_cnt_reg + 12'd1;
          bus_addr_next = owner_addr;
          bus_wr_next   = (owner_reg != SRC_RD);
        end
      end

      GAP: begin
        if (gap_cnt_reg == GAP_W'(GAP_CYCLES)) begin
          state_next    = IDLE;
          bus_busy_next = 1'b0;
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end

      default: begin
        state_next    = IDLE;
        gnt_next      = 3'b000;
        bus_addr_next = '0;
        bus_wr_next   = 1'b0;
        bus_busy_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      owner_reg    <= SRC_INIT;
      hold_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      lock_reg     <= '0;
      gnt_reg      <= '0;
      bus_addr_reg <= '0;
      bus_wr_reg   <= 1'b0;
      bus_busy_reg <= 1'b0;
      timeout_reg  <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_wr_reg  <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
      lock_reg     <= lock_next;
      gnt_reg      <= gnt_next;
      bus_addr_reg <= bus_addr_next;
      bus_wr_reg   <= bus_wr_next;
      bus_busy_reg <= bus_busy_next;
      timeout_reg  <= timeout_next;
`ifdef ROUND_ROBIN_EN
      last_wr_reg  <= last_wr_next;
`endif
    end
  end

  assign gnt_init = gnt_reg[0];
  assign gnt_wr   = gnt_reg[1];
  assign gnt_rd   = gnt_reg[2];
  assign bus_addr = bus_addr_reg;
  assign bus_wr   = bus_wr_reg;
  assign bus_busy = bus_busy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Arbitrates the shared RTC address/control bus between three requesters: initialisation sequencer, write (set-time) machine and read (display-refresh) sequencer.
- Sits between those three sequencers and the RTC bus interface.
- Grants one owner at a time, bounds each ownership with a timeout, and inserts a bus turnaround gap between owners.

Parameters:
- HOLD_MAX, 12'h04a: maximum cycles one owner may hold the bus per grant before forced release.
- GAP_CYCLES, 4: idle turnaround cycles between consecutive grants (minimum 1).
- ADDR_W, 8: address bus width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req_init  in  1  initialisation sequencer requests the bus.
- req_wr  in  1  write machine requests the bus.
- req_rd  in  1  read sequencer requests the bus.
- addr_init  in  ADDR_W  address driven by the initialisation sequencer.
- addr_wr  in  ADDR_W  address driven by the write machine.
- addr_rd  in  ADDR_W  address driven by the read sequencer.
- gnt_init  out  1  initialisation sequencer owns the bus.
- gnt_wr  out  1  write machine owns the bus.
- gnt_rd  out  1  read sequencer owns the bus.
- bus_addr  out  ADDR_W  registered address of the current owner.
- bus_wr  out  1  1 = write cycle (owner is init or wr), 0 = read.
- bus_busy  out  1  1 in OWN or GAP.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset: when reset=0 at a rising edge, all outputs go to 0 (bus_addr = 0x00) on that edge, FSM goes to IDLE, counters and lockouts clear. This applies mid-grant too; there is no gap after reset.
- Grants are one-hot or all zero; never more than one grant high.
- FSM states: IDLE, OWN, GAP.
- IDLE:
  - If any eligible req is high, the next edge enters OWN with the winner's grant high.
  - Grant latency is 1 cycle from req.
  - Fixed priority: init > wr > rd.
- OWN:
  - bus_addr <= owner's addr and bus_wr <= (owner != rd) every cycle, so address changes follow with 1-cycle latency.
  - The hold counter starts at 1 on grant and increments each OWN cycle.
- Release in OWN:
  - Normal release: owner's req low at an edge → grant drops, bus_addr = 0x00, enter GAP.
  - Forced release: counter == HOLD_MAX with req still high → same as normal release, plus timeout = 1 for one cycle.
  - After a forced release, that requester is locked out until it deasserts its req for at least one cycle.
  - If req drops on the same edge the counter hits HOLD_MAX, it is a normal release: no timeout and no lockout.
- GAP:
  - All grants 0, bus_addr = 0x00, bus_busy = 1.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
  - Requests arriving during GAP are not lost; they are evaluated in IDLE.
- Higher-priority requests do not preempt a current owner.
- Counter width: 12 bits; no wrap is possible because release occurs at HOLD_MAX.
- Lockout clears only on req low; reset also clears it.

Optional Feature:
- ROUND_ROBIN_EN
  - Defined: init keeps absolute priority. Between wr and rd, the requester not granted most recently wins when both are eligible. The last-granted flag resets to rd, so wr wins the first tie.
  - Undefined: fixed priority init > wr > rd; rd can starve while wr keeps re-requesting.

Test Plan:
- Reset mid-grant: rd owning with bus_addr 0x23, reset=0 for one edge → all grants 0, bus_addr 0x00, bus_busy 0 on that edge; FSM in IDLE next cycle.
- Simultaneous request: req_wr, req_rd rise together in IDLE with addr_wr=0x21 → gnt_wr=1 after 1 cycle, bus_addr=0x21 one cycle later, bus_wr=1, gnt_rd=0.
- Gap timing: rd owner drops req; req_wr high throughout → exactly GAP_CYCLES=4 cycles of all grants 0 and bus_addr 0x00, then IDLE, then gnt_wr one cycle later.
- Timeout: req_rd held high continuously → timeout pulses once when the counter reaches 0x04a; gnt_rd drops; rd is not re-granted until req_rd goes low for one cycle and high again.
- Boundary release: req_rd drops on the exact edge the counter reaches HOLD_MAX → timeout stays 0 and there is no lockout; rd is regranted on its next request after the gap.
- ROUND_ROBIN_EN: wr and rd both requesting continuously with 3-cycle grants → grants alternate wr, rd, wr. Without the macro → wr, wr, wr.
